head_sprite_reader: RTL
=======================

Name: head_sprite_reader

Overview:
- Read side of the 16x16 snake-head sprite ROM (8-bit address, 24-bit RGB).
- Takes the VGA scan position and the head's latched position and direction, then drives the ROM address with rotation.
- Registers the returned pixel and flags transparent pixels.
- Its output feeds the frame compositor, which overlays the head on the board layer.

Parameters:
- SPRITE_SIZE, 16, sprite edge in pixels; must be a power of two.
- COORD_W, 10, width of pixel coordinates.
- KEY_COLOR, 24'h1a1a1c, transparent background colour in ROM data.

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  synchronous active-high reset
- i_frame_start  in  1  one-cycle pulse at start of vertical blank; latches head state
- i_head_x  in  COORD_W  head sprite top-left x (pixels)
- i_head_y  in  COORD_W  head sprite top-left y (pixels)
- i_dir  in  2  0=UP, 1=RIGHT, 2=DOWN, 3=LEFT
- i_pix_valid  in  1  scan pixel valid (active video)
- i_pix_x  in  COORD_W  current scan x
- i_pix_y  in  COORD_W  current scan y
- o_rom_addr  out  8  address to sprite ROM; ROM is combinational, data returns the same cycle
- i_rom_data  in  24  ROM pixel data
- o_valid  out  1  output pixel valid
- o_hit  out  1  pixel is inside the sprite and not KEY_COLOR
- o_rgb  out  24  sprite colour when o_hit, else 0

Behaviour:
- Reset:
  - o_valid=0, o_hit=0, o_rgb=0, o_rom_addr=0.
  - Shadow head_x=0, head_y=0, dir=UP.
  - All pipeline valid/in-box flags cleared.
- Shadow registers:
  - On i_frame_start, latch i_head_x, i_head_y and i_dir.
  - Head state never changes mid-frame; a direction change mid-frame is invisible until the next i_frame_start.
  - If i_frame_start and i_pix_valid coincide, stage 1 uses the old shadow values; the new values apply from the next cycle.
- Stage 1 (cycle after i_pix_valid):
  - Compute dx = pix_x - head_x and dy = pix_y - head_y at COORD_W+1 bits (signed).
  - in_box = dx and dy are both in [0, SPRITE_SIZE-1]. Negative differences and wrap-around are never treated as inside.
  - Take local r=dy[3:0], c=dx[3:0] and map to the source pixel:
    - UP: (r, c)
    - RIGHT: (15-c, r)
    - DOWN: (15-r, 15-c)
    - LEFT: (c, 15-r)
  - Register o_rom_addr = src_r*16 + src_c, s1_valid = i_pix_valid, s1_in = in_box.
  - When not in_box, o_rom_addr holds its previous value; this avoids ROM toggling.
- Stage 2:
  - o_valid = s1_valid.
  - o_hit = s1_valid & s1_in & (i_rom_data != KEY_COLOR).
  - o_rgb = o_hit ? i_rom_data : 0.
- Latency is exactly 2 cycles from i_pix_valid to o_valid, at a throughput of one pixel per cycle with no stalls.
- Gaps in i_pix_valid propagate as o_valid=0, with o_hit=0 and o_rgb=0.
- Sprite partly off-screen (e.g. head_x=630): in-screen pixels render normally; off-screen coordinates never arrive.
- Reset asserted mid-line: outputs are 0 on the cycle after reset, and the pipeline is flushed. Resuming needs a new i_frame_start, otherwise the sprite renders at (0,0) facing UP.

Decomposition:
- Shared package snake_gfx_pkg holds:
  - dir_t enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT)
  - SPRITE_SIZE, KEY_COLOR and COORD_W constants
  - rgb_t typedef (24-bit)
- One natural sub-module: sprite_rotate_addr. It is combinational and maps (r, c, dir) to an 8-bit address, and is reused by the body and apple sprite readers.
- Shadow registers and the pipeline stay in the top level.

Test Plan:
- Reset, then frame_start with head=(100,50), dir=UP; scan pixel (105,50):
  - addr=5 two cycles later; ROM returns cf212b, so o_hit=1, o_rgb=cf212b.
  - Pixel (100,50) gives addr=0; data 1a1a1c gives o_hit=0, o_rgb=0, o_valid=1.
- dir=RIGHT, head=(0,0); scan pixel (0,0) (r=0, c=0):
  - Source (15,0) gives addr=240.
  - dir=DOWN, same pixel, gives addr=255; dir=LEFT gives addr=15.
- Bounds with head=(100,50):
  - Pixels (99,50), (116,50) and (100,66) give o_hit=0.
  - Pixel (115,65) is in-box and gives addr=255 under UP.
  - Head=(0,0) with pixel (639,479): no wrap to in-box, o_hit=0.
- Change i_dir and i_head_x mid-frame without frame_start:
  - Addresses keep using the old values.
  - After the frame_start pulse, the next pixel uses the new values.
  - frame_start coincident with pix_valid still uses the old values for that pixel.
- Drive i_pix_valid in the pattern 1,0,1,1,0 inside the box:
  - o_valid reproduces 1,0,1,1,0 delayed by 2 cycles.
  - o_hit=0 and o_rgb=0 wherever o_valid=0.
- Assert i_rst for one cycle while streaming in-box pixels:
  - All outputs are 0 the next cycle and o_valid stays 0 for 2 cycles.
  - Shadow state returns to (0,0), UP.

Source files
------------

// File: rtl/snake_gfx_pkg.sv
// Shared types and constants for the snake sprite readers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snake_gfx_pkg;

    localparam int SPRITE_SIZE = 16;
    localparam int COORD_W     = 10;

    typedef logic [23:0] rgb_t;

    localparam rgb_t KEY_COLOR = 24'h1a1a1c;

    // Facing of a sprite; the encoding matches the direction input of the readers.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

endpackage

// File: rtl/sprite_rotate_addr.sv
// Maps a local sprite (row, col) plus facing to a rotated source ROM address.
// Latency: combinational.
// Backpressure: none.
module sprite_rotate_addr
    import snake_gfx_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0]   i_row,
    input  logic [IDX_W-1:0]   i_col,
    input  dir_t               i_dir,
    output logic [2*IDX_W-1:0] o_addr
);

    // Edge-1 minus an index is a bitwise invert because the edge is a power of two.
    always_comb begin
        o_addr = {i_row, i_col};
        case (i_dir)
            DIR_UP:    o_addr = {i_row, i_col};
            DIR_RIGHT: o_addr = {~i_col, i_row};
            DIR_DOWN:  o_addr = {~i_row, ~i_col};
            DIR_LEFT:  o_addr = {i_col, ~i_row};
            default:   o_addr = {i_row, i_col};
        endcase
    end

endmodule

// File: rtl/head_sprite_reader.sv
// Snake-head sprite read pipeline: scan position -> rotated ROM address -> keyed pixel.
// Latency: 2 cycles from i_pix_valid to o_valid.
// Backpressure: none, one pixel per cycle; gaps in i_pix_valid pass through as o_valid=0.
module head_sprite_reader #(
    parameter int          SPRITE_SIZE = snake_gfx_pkg::SPRITE_SIZE,
    parameter int          COORD_W     = snake_gfx_pkg::COORD_W,
    parameter logic [23:0] KEY_COLOR   = snake_gfx_pkg::KEY_COLOR
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_frame_start,
    input  logic [COORD_W-1:0] i_head_x,
    input  logic [COORD_W-1:0] i_head_y,
    input  logic [1:0]         i_dir,
    input  logic               i_pix_valid,
    input  logic [COORD_W-1:0] i_pix_x,
    input  logic [COORD_W-1:0] i_pix_y,
    output logic [7:0]         o_rom_addr,
    input  logic [23:0]        i_rom_data,
    output logic               o_valid,
    output logic               o_hit,
    output logic [23:0]        o_rgb
);

    import snake_gfx_pkg::*;

    localparam int IDX_W = $clog2(SPRITE_SIZE);

    // Head state shadowed once per frame so the sprite never tears mid-frame.
    logic [COORD_W-1:0] head_x_q, head_x_d;
    logic [COORD_W-1:0] head_y_q, head_y_d;
    dir_t               dir_q, dir_d;

    // Stage 1: address issue.
    logic [COORD_W:0]      dx, dy;
    logic                  in_box;
    logic [2*IDX_W-1:0]    rot_addr;
    logic [2*IDX_W-1:0]    rom_addr_q, rom_addr_d;
    logic                  s1_valid_q;
    logic                  s1_in_q;

    // Stage 2: keyed pixel.
    logic                  valid_q;
    logic                  hit_q, hit_d;
    rgb_t                  rgb_q, rgb_d;

    // Next shadow state: load on frame start, otherwise hold.
    always_comb begin
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        dir_d    = dir_q;
        if (i_frame_start) begin
            head_x_d = i_head_x;
            head_y_d = i_head_y;
            dir_d    = dir_t'(i_dir);
        end
    end

    // Shadow head registers; a coincident pixel still sees the old values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_x_q <= '0;
            head_y_q <= '0;
            dir_q    <= DIR_UP;
        end else begin
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            dir_q    <= dir_d;
        end
    end

    // One extra bit keeps negative offsets distinct from large positive ones,
    // so pixels left/above the sprite or wrapped coordinates never land in-box.
    always_comb begin
        dx     = {1'b0, i_pix_x} - {1'b0, head_x_q};
        dy     = {1'b0, i_pix_y} - {1'b0, head_y_q};
        in_box = (dx[COORD_W:IDX_W] == '0) && (dy[COORD_W:IDX_W] == '0);
    end

    sprite_rotate_addr #(
        .IDX_W (IDX_W)
    ) u_rot (
        .i_row  (dy[IDX_W-1:0]),
        .i_col  (dx[IDX_W-1:0]),
        .i_dir  (dir_q),
        .o_addr (rot_addr)
    );

    // Only move the ROM address for in-box pixels to keep the ROM quiet elsewhere.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (i_pix_valid && in_box) begin
            rom_addr_d = rot_addr;
        end
    end

    // Stage 1 registers: address plus valid/in-box flags travelling with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rom_addr_q <= '0;
            s1_valid_q <= 1'b0;
            s1_in_q    <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            s1_valid_q <= i_pix_valid;
            s1_in_q    <= in_box;
        end
    end

    // Hit needs a live, in-box pixel whose colour is not the transparent key.
    always_comb begin
        hit_d = s1_valid_q && s1_in_q && (i_rom_data != KEY_COLOR);
        rgb_d = hit_d ? i_rom_data : '0;
    end

    // Stage 2 registers feeding the compositor.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            rgb_q   <= '0;
        end else begin
            valid_q <= s1_valid_q;
            hit_q   <= hit_d;
            rgb_q   <= rgb_d;
        end
    end

    assign o_rom_addr = rom_addr_q;
    assign o_valid    = valid_q;
    assign o_hit      = hit_q;
    assign o_rgb      = rgb_q;

endmodule
